// File: rtl/lpc_pkg.sv
// Shared LPC constants, FSM state encoding and the completed-cycle record layout.
package lpc_pkg;

    localparam logic [3:0] START_IO   = 4'h0;
    localparam logic [3:0] START_TPM  = 4'h5;

    localparam logic [3:0] CYC_IO_RD  = 4'h0;
    localparam logic [3:0] CYC_IO_WR  = 4'h2;

    localparam logic [3:0] SYNC_READY = 4'h0;
    localparam logic [3:0] SYNC_LWAIT = 4'h6;
    localparam logic [3:0] SYNC_ERR   = 4'hA;
    localparam logic [3:0] LAD_TAR    = 4'hF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_CYCTYPE,
        ST_ADDR,
        ST_WDATA,
        ST_TAR1,
        ST_TAR2,
        ST_SYNC,
        ST_RDATA,
        ST_FTAR1,
        ST_FTAR2
    } lpc_state_e;

    // Record bit offsets: [31:28] start, [27:12] addr, [11:4] data, [3:1] window, [0] write
    localparam int unsigned REC_START_LSB = 28;
    localparam int unsigned REC_ADDR_LSB  = 12;
    localparam int unsigned REC_DATA_LSB  = 4;
    localparam int unsigned REC_WIN_LSB   = 1;
    localparam int unsigned REC_WR_BIT    = 0;

    typedef struct packed {
        logic [3:0]  start;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [2:0]  win;
        logic        wr;
    } lpc_rec_t;

    localparam int unsigned REC_W = $bits(lpc_rec_t);

    // True when a LAD nibble is an accepted START code
    function automatic logic is_start(input logic [3:0] lad, input logic tpm_en);
        return (lad == START_IO) || (tpm_en && (lad == START_TPM));
    endfunction

endpackage

// File: rtl/lpc_rec_fifo.sv
// Synchronous first-word-fall-through FIFO for completed-cycle records.
module lpc_rec_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when a pop frees a slot in the same clock
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/lpc_periph_multi.sv
// Multi-window LPC I/O / TPM peripheral with read request port and record FIFO.
module lpc_periph_multi
    import lpc_pkg::*;
#(
    parameter int unsigned NUM_WIN       = 2,
    parameter int unsigned WIN_SIZE_LOG2 = 3,
    parameter bit          TPM_EN        = 1'b1,
    parameter int unsigned MAX_WAIT      = 16,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                   clk_i,
    input  logic                   nrst_i,
    input  logic                   lframe_i,
    input  logic [3:0]             lad_i,
    output logic [3:0]             lad_o,
    output logic                   lad_oe_o,
    input  logic [16*NUM_WIN-1:0]  win_base_i,
    input  logic [NUM_WIN-1:0]     win_en_i,
    output logic                   rd_req_o,
    output logic [15:0]            rd_addr_o,
    input  logic [7:0]             rd_data_i,
    input  logic                   rd_ack_i,
    output logic [31:0]            tdata_o,
    output logic                   tvalid_o,
    input  logic                   tready_i,
    output logic [7:0]             drop_cnt_o
);

    localparam int unsigned WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [15:0] WIN_MASK = 16'(16'hFFFF << WIN_SIZE_LOG2);

    lpc_state_e        state_q;
    logic [3:0]        start_q;
    logic              wr_q;
    logic [15:0]       addr_q;
    logic [7:0]        data_q;
    logic [2:0]        win_q;
    logic [1:0]        cnt_q;
    logic [WAIT_W-1:0] wait_q;
    logic [3:0]        lad_q;
    logic              rd_req_q;
    logic [15:0]       rd_addr_q;
    logic [7:0]        drop_cnt_q;

    logic              hit_c;
    logic [2:0]        hit_idx_c;
    logic              start_ok_c;
    logic              abort_c;
    logic              space_c;
    logic              push_c;
    logic              pop_c;
    logic              fifo_full;
    logic              fifo_empty;
    lpc_rec_t          rec_c;

    // Window decode; iterating downward leaves the lowest hit index in place
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int k = int'(NUM_WIN) - 1; k >= 0; k--) begin
            if (win_en_i[k] && (((addr_q ^ win_base_i[16*k +: 16]) & WIN_MASK) == '0)) begin
                hit_c     = 1'b1;
                hit_idx_c = 3'(k);
            end
        end
    end

    assign start_ok_c = is_start(lad_i, TPM_EN);
    assign abort_c    = !lframe_i && (state_q != ST_IDLE) && (state_q != ST_START);
    assign pop_c      = tready_i && !fifo_empty;
    // A pop in this clock frees room for the record pushed at the end of SYNC
    assign space_c    = !fifo_full || pop_c;
    // Successful cycles record on FTAR1 entry; aborts and error SYNC never do
    assign push_c     = lframe_i &&
                        (((state_q == ST_SYNC) && wr_q && (lad_q == SYNC_READY)) ||
                         ((state_q == ST_RDATA) && (cnt_q == 2'd1)));

    assign rec_c = '{start: start_q, addr: addr_q, data: data_q, win: win_q, wr: wr_q};

    // Cycle FSM with registered LAD drive, read request and drop counter
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q    <= ST_IDLE;
            start_q    <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            win_q      <= '0;
            cnt_q      <= '0;
            wait_q     <= '0;
            lad_q      <= '0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            lad_q <= '0;
            cnt_q <= '0;
            if (abort_c) begin
                rd_req_q <= 1'b0;
                if (start_ok_c) begin
                    state_q <= ST_START;
                    start_q <= lad_i;
                end else begin
                    state_q <= ST_IDLE;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (!lframe_i && start_ok_c) begin
                            state_q <= ST_START;
                            start_q <= lad_i;
                        end
                    end
                    ST_START: begin
                        if (lframe_i) begin
                            state_q <= ST_CYCTYPE;
                        end else if (start_ok_c) begin
                            start_q <= lad_i;
                        end
                    end
                    ST_CYCTYPE: begin
                        if (lad_i == CYC_IO_RD) begin
                            wr_q    <= 1'b0;
                            state_q <= ST_ADDR;
                        end else if (lad_i == CYC_IO_WR) begin
                            wr_q    <= 1'b1;
                            state_q <= ST_ADDR;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_ADDR: begin
                        addr_q <= {addr_q[11:0], lad_i};
                        if (cnt_q == 2'd3) begin
                            state_q <= wr_q ? ST_WDATA : ST_TAR1;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                    ST_WDATA: begin
                        if (cnt_q == 2'd0) begin
                            data_q[3:0] <= lad_i;
                            cnt_q       <= 2'd1;
                        end else begin
                            data_q[7:4] <= lad_i;
                            state_q     <= ST_TAR1;
                        end
                    end
                    ST_TAR1: begin
                        if (hit_c) begin
                            win_q   <= hit_idx_c;
                            state_q <= ST_TAR2;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_TAR2: begin
                        state_q <= ST_SYNC;
                        wait_q  <= '0;
                        if (wr_q) begin
                            lad_q <= space_c ? SYNC_READY : SYNC_LWAIT;
                        end else begin
                            lad_q     <= SYNC_LWAIT;
                            rd_req_q  <= 1'b1;
                            rd_addr_q <= addr_q;
                        end
                    end
                    ST_SYNC: begin
                        if (lad_q == SYNC_READY) begin
                            if (wr_q) begin
                                state_q <= ST_FTAR1;
                                lad_q   <= LAD_TAR;
                            end else begin
                                state_q <= ST_RDATA;
                                lad_q   <= data_q[3:0];
                            end
                        end else if (lad_q == SYNC_ERR) begin
                            state_q <= ST_FTAR1;
                            lad_q   <= LAD_TAR;
                        end else if (!wr_q && rd_req_q && rd_ack_i) begin
                            data_q   <= rd_data_i;
                            rd_req_q <= 1'b0;
                            lad_q    <= SYNC_READY;
                        end else if (wr_q && space_c) begin
                            lad_q <= SYNC_READY;
                        end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                            lad_q    <= SYNC_ERR;
                            rd_req_q <= 1'b0;
                            if (wr_q && (drop_cnt_q != 8'hFF)) begin
                                drop_cnt_q <= drop_cnt_q + 8'd1;
                            end
                        end else begin
                            wait_q <= wait_q + WAIT_W'(1);
                            lad_q  <= SYNC_LWAIT;
                        end
                    end
                    ST_RDATA: begin
                        if (cnt_q == 2'd0) begin
                            lad_q <= data_q[7:4];
                            cnt_q <= 2'd1;
                        end else begin
                            state_q <= ST_FTAR1;
                            lad_q   <= LAD_TAR;
                        end
                    end
                    ST_FTAR1: state_q <= ST_FTAR2;
                    ST_FTAR2: state_q <= ST_IDLE;
                    default:  state_q <= ST_IDLE;
                endcase
            end
        end
    end

    lpc_rec_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .nrst_i  (nrst_i),
        .push_i  (push_c),
        .data_i  (rec_c),
        .pop_i   (pop_c),
        .data_o  (tdata_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Bus is released the same clock LFRAME# falls
    assign lad_oe_o   = lframe_i && (state_q inside {ST_SYNC, ST_RDATA, ST_FTAR1});
    assign lad_o      = lad_q;
    assign rd_req_o   = rd_req_q;
    assign rd_addr_o  = rd_addr_q;
    assign tvalid_o   = !fifo_empty;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_lpc_periph_multi.sv
// Scoreboard bench for lpc_periph_multi: expected LAD drive nibbles and records are
// queued as stimulus is issued and retired by a monitor on the falling clock edge.
module tb_lpc_periph_multi;

    logic        clk = 1'b0;
    logic        nrst_i;
    logic        lframe_i;
    logic [3:0]  lad_i;
    logic [3:0]  lad_o;
    logic        lad_oe_o;
    logic [31:0] win_base_i;
    logic [1:0]  win_en_i;
    logic        rd_req_o;
    logic [15:0] rd_addr_o;
    logic [7:0]  rd_data_i;
    logic        rd_ack_i;
    logic [31:0] tdata_o;
    logic        tvalid_o;
    logic        tready_i;
    logic [7:0]  drop_cnt_o;

    int checks   = 0;
    int failures = 0;
    int oe_clks  = 0;

    logic [3:0]  exp_lad[$];
    logic [31:0] exp_rec[$];

    always #5 clk = ~clk;

    lpc_periph_multi #(
        .NUM_WIN       (2),
        .WIN_SIZE_LOG2 (3),
        .TPM_EN        (1'b1),
        .MAX_WAIT      (16),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk_i      (clk),
        .nrst_i     (nrst_i),
        .lframe_i   (lframe_i),
        .lad_i      (lad_i),
        .lad_o      (lad_o),
        .lad_oe_o   (lad_oe_o),
        .win_base_i (win_base_i),
        .win_en_i   (win_en_i),
        .rd_req_o   (rd_req_o),
        .rd_addr_o  (rd_addr_o),
        .rd_data_i  (rd_data_i),
        .rd_ack_i   (rd_ack_i),
        .tdata_o    (tdata_o),
        .tvalid_o   (tvalid_o),
        .tready_i   (tready_i),
        .drop_cnt_o (drop_cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Monitor: every driven LAD clock and every accepted record retires one expectation
    always @(negedge clk) begin
        if (nrst_i) begin
            if (lad_oe_o) begin
                oe_clks++;
                if (exp_lad.size() == 0) begin
                    chk("lad_unexpected_drive", 32'(lad_o), 32'hFFFF_FFFF);
                end else begin
                    chk("lad", 32'(lad_o), 32'(exp_lad.pop_front()));
                end
            end
            if (tvalid_o && tready_i) begin
                if (exp_rec.size() == 0) begin
                    chk("record_unexpected", tdata_o, 32'hFFFF_FFFF);
                end else begin
                    chk("record", tdata_o, exp_rec.pop_front());
                end
            end
        end
    end

    task automatic tick(input logic f, input logic [3:0] l);
        lframe_i = f;
        lad_i    = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 4'hF);
    endtask

    // Everything after the START nibble up to SYNC entry
    task automatic body(input logic wr, input logic [15:0] a, input logic [7:0] d);
        logic [3:0] c;
        c = wr ? 4'h2 : 4'h0;
        tick(1'b1, c);
        tick(1'b1, c);
        tick(1'b1, a[15:12]);
        tick(1'b1, a[11:8]);
        tick(1'b1, a[7:4]);
        tick(1'b1, a[3:0]);
        if (wr) begin
            tick(1'b1, d[3:0]);
            tick(1'b1, d[7:4]);
        end
        tick(1'b1, 4'hF);
        tick(1'b1, 4'hF);
    endtask

    task automatic cycle(input logic [3:0] st, input logic wr, input logic [15:0] a,
                         input logic [7:0] d);
        tick(1'b0, st);
        body(wr, a, d);
    endtask

    task automatic push_lad(input logic [3:0] v, input int n);
        for (int i = 0; i < n; i++) exp_lad.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] fill_rec [4];
        int o;
        fill_rec[0] = 32'h0008_0101;
        fill_rec[1] = 32'h0008_1111;
        fill_rec[2] = 32'h0008_2121;
        fill_rec[3] = 32'h0008_3131;

        nrst_i     = 1'b0;
        lframe_i   = 1'b1;
        lad_i      = 4'hF;
        win_base_i = {16'hD408, 16'h0080};
        win_en_i   = 2'b11;
        rd_data_i  = 8'h00;
        rd_ack_i   = 1'b0;
        tready_i   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_lad_oe", 32'(lad_oe_o), 32'h0);
        chk("rst_lad", 32'(lad_o), 32'h0);
        chk("rst_rd_req", 32'(rd_req_o), 32'h0);
        chk("rst_rd_addr", 32'(rd_addr_o), 32'h0);
        chk("rst_tvalid", 32'(tvalid_o), 32'h0);
        chk("rst_tdata", tdata_o, 32'h0);
        chk("rst_drop", 32'(drop_cnt_o), 32'h0);
        nrst_i = 1'b1;
        idle(2);

        // I/O write 0x0080 <- 0x5A, window 0, FIFO has room
        exp_lad.push_back(4'h0);
        exp_lad.push_back(4'hF);
        exp_rec.push_back(32'h0008_05A1);
        cycle(4'h0, 1'b1, 16'h0080, 8'h5A);
        idle(4);

        // TPM read 0xD40C via window 1, acknowledged in the third SYNC clock
        push_lad(4'h6, 3);
        exp_lad.push_back(4'h0);
        exp_lad.push_back(4'h3);
        exp_lad.push_back(4'hC);
        exp_lad.push_back(4'hF);
        exp_rec.push_back(32'h5D40_CC32);
        cycle(4'h5, 1'b0, 16'hD40C, 8'h00);
        chk("tpm_rd_req", 32'(rd_req_o), 32'h1);
        chk("tpm_rd_addr", 32'(rd_addr_o), 32'h0000_D40C);
        idle(2);
        rd_data_i = 8'hC3;
        rd_ack_i  = 1'b1;
        tick(1'b1, 4'hF);
        rd_ack_i  = 1'b0;
        chk("tpm_rd_req_clear", 32'(rd_req_o), 32'h0);
        idle(6);

        // Read with no window hit: bus never driven, no request
        o = oe_clks;
        cycle(4'h0, 1'b0, 16'h1234, 8'h00);
        chk("nohit_rd_req", 32'(rd_req_o), 32'h0);
        idle(4);
        chk("nohit_oe_clks", 32'(oe_clks - o), 32'h0);

        // Read never acknowledged: 16 long waits then error SYNC
        push_lad(4'h6, 16);
        exp_lad.push_back(4'hA);
        exp_lad.push_back(4'hF);
        cycle(4'h0, 1'b0, 16'h0081, 8'h00);
        chk("tmo_rd_addr", 32'(rd_addr_o), 32'h0000_0081);
        idle(15);
        chk("tmo_rd_req_held", 32'(rd_req_o), 32'h1);
        idle(1);
        chk("tmo_rd_req_drop", 32'(rd_req_o), 32'h0);
        idle(4);

        // Fill the FIFO with the sink stalled
        tready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_lad.push_back(4'h0);
            exp_lad.push_back(4'hF);
            exp_rec.push_back(fill_rec[i]);
            cycle(4'h0, 1'b1, 16'h0080 + 16'(i), 8'h10 + 8'(i));
            idle(4);
        end

        // Write into a full FIFO: error SYNC and one drop
        push_lad(4'h6, 16);
        exp_lad.push_back(4'hA);
        exp_lad.push_back(4'hF);
        cycle(4'h0, 1'b1, 16'h0084, 8'h77);
        idle(16);
        chk("drop_cnt", 32'(drop_cnt_o), 32'h1);
        idle(4);

        // Write into a full FIFO, sink released during the fifth wait clock
        push_lad(4'h6, 5);
        exp_lad.push_back(4'h0);
        exp_lad.push_back(4'hF);
        exp_rec.push_back(32'h0008_5991);
        cycle(4'h0, 1'b1, 16'h0085, 8'h99);
        idle(4);
        tready_i = 1'b1;
        idle(1);
        chk("space_sync_ready", 32'(lad_o), 32'h0);
        idle(8);

        // Zero-wait read aborted during RDATA by a new START, then a write follows
        exp_lad.push_back(4'h6);
        exp_lad.push_back(4'h0);
        cycle(4'h5, 1'b0, 16'hD40C, 8'h00);
        rd_data_i = 8'h96;
        rd_ack_i  = 1'b1;
        tick(1'b1, 4'hF);
        rd_ack_i  = 1'b0;
        tick(1'b1, 4'hF);
        lframe_i = 1'b0;
        lad_i    = 4'h0;
        #3;
        chk("abort_oe", 32'(lad_oe_o), 32'h0);
        @(posedge clk);
        #1;
        exp_lad.push_back(4'h0);
        exp_lad.push_back(4'hF);
        exp_rec.push_back(32'h0008_0111);
        body(1'b1, 16'h0080, 8'h11);
        idle(5);

        for (int i = 0; i < 50 && (exp_lad.size() != 0 || exp_rec.size() != 0); i++) idle(1);
        chk("lad_queue_empty", 32'(exp_lad.size()), 32'h0);
        chk("rec_queue_empty", 32'(exp_rec.size()), 32'h0);
        chk("final_drop_cnt", 32'(drop_cnt_o), 32'h1);
        chk("final_tvalid", 32'(tvalid_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lpc_periph_multi.md
# lpc_periph_multi

Parametrised LPC peripheral that succeeds the single-window I/O peripheral. It decodes LPC I/O and TPM-locality read/write cycles against `NUM_WIN` programmable address windows and serves reads through a request/acknowledge port, inserting long-wait SYNC while the port is pending. It also queues every completed cycle as a 32-bit record in a valid/ready FIFO. It sits between the LPC pins (split tristate) and the board-side register/TPM logic.

## Interface
- `NUM_WIN`, 2: number of address windows (1..8).
- `WIN_SIZE_LOG2`, 3: log2 of the byte size of each window; base low bits are ignored.
- `TPM_EN`, 1: accept START 0x5 (TPM) in addition to START 0x0 (I/O).
- `MAX_WAIT`, 16: maximum long-wait SYNC clocks before SYNC error.
- `FIFO_DEPTH`, 4: record FIFO depth, power of two, ≥2.
- `clk_i`  in  1  LPC clock.
- `nrst_i`  in  1  Reset; one clock, asynchronous, active-low.
- `lframe_i`  in  1  LFRAME#, active low.
- `lad_i`  in  4  LAD sampled from pad.
- `lad_o`  out  4  LAD drive value.
- `lad_oe_o`  out  1  LAD output enable.
- `win_base_i`  in  16*NUM_WIN  Window base addresses; window k occupies bits [16k+15:16k].
- `win_en_i`  in  NUM_WIN  Per-window enable.
- `rd_req_o`  out  1  Read request; held until `rd_ack_i`.
- `rd_addr_o`  out  16  Read address; valid while `rd_req_o` is high.
- `rd_data_i`  in  8  Read data, sampled with `rd_ack_i`.
- `rd_ack_i`  in  1  Read acknowledge, single-cycle pulse.
- `tdata_o`  out  32  Record: [31:28] START code, [27:12] address, [11:4] data, [3:1] window index, [0] 1 = write.
- `tvalid_o`  out  1  Record valid.
- `tready_i`  in  1  Record accepted.
- `drop_cnt_o`  out  8  Saturating count of records dropped because the FIFO was full.

## Operation
- States: IDLE, START, CYCTYPE, ADDR, WDATA, TAR1, TAR2, SYNC, RDATA, FTAR1, FTAR2.
- IDLE → START when `lframe_i`=0 and `lad_i` is 0x0, or 0x5 with `TPM_EN`=1. START stays in START while `lframe_i`=0 and latches the last START nibble. START → CYCTYPE when `lframe_i`=1.
- CYCTYPE: 0x0 = read, 0x2 = write → ADDR. Any other value → IDLE.
- ADDR: 4 nibbles, MSB first, driven by a 2-bit counter. Then WDATA (write) or TAR1 (read).
- WDATA: 2 nibbles, low nibble first → TAR1.
- TAR1 → TAR2: the window hit is evaluated here. Hit means `win_en_i[k]` and `addr[15:WIN_SIZE_LOG2]==win_base_i[k][15:WIN_SIZE_LOG2]`. The lowest hit index wins. No hit → IDLE and the bus is never driven.
- TAR2 → SYNC. `rd_req_o` rises on SYNC entry for reads.
- SYNC drives 0x6 (long wait) while waiting and 0x0 when ready:
  - Read: ready on the clock after `rd_ack_i`.
  - Write: ready when the FIFO is not full.
  - After `MAX_WAIT` wait clocks, drive 0xA (error) instead. The read request is withdrawn, and the write record is dropped with `drop_cnt_o`+1.
- SYNC → RDATA (read, 2 nibbles, low first) or → FTAR1 (write).
- RDATA → FTAR1. FTAR1 drives 0xF. FTAR2 releases the bus → IDLE.
- A record is pushed on FTAR1 entry for successful cycles only. Error-SYNC cycles push no record.
- `lframe_i`=0 in any state other than IDLE/START aborts the cycle:
  - `lad_oe_o` drops the same clock (combinational on `lframe_i`).
  - `rd_req_o` clears.
  - No record is pushed.
  - Next state is START if `lad_i` is a valid START code, else IDLE.

## Timing
- Reset values: `lad_oe_o`=0, `lad_o`=0x0, `rd_req_o`=0, `rd_addr_o`=0, `tvalid_o`=0, `tdata_o`=0, `drop_cnt_o`=0. State is IDLE and the FIFO is empty. Reset mid-cycle releases the bus immediately.
- `lad_oe_o`=1 exactly in SYNC, RDATA and FTAR1, and is decoded from the registered state.
- `lad_o` is registered and valid in the same clock as `lad_oe_o`.
- Zero-wait read: `rd_ack_i` in the first SYNC clock gives one 0x6 clock followed by one 0x0 clock.
- A write with the FIFO not full gives SYNC 0x0 in the first SYNC clock.
- FIFO: push and pop in the same clock on a full FIFO are both accepted. `tvalid_o` rises 1 clock after the push. Data is first-word-fall-through.
- `drop_cnt_o` saturates at 255.

## Structure
- Shared package `lpc_pkg`: START codes (0x0, 0x5), cycle-type codes, SYNC codes (0x0, 0x6, 0xA), state enum, record field offsets.
- Sub-module `lpc_rec_fifo` (synchronous FIFO, parameters width/depth, outputs full/empty). The FSM, window decode and SYNC wait counter stay in the top.

## Test plan
- I/O write 0x0080 ← 0x5A with window 0 at 0x0080 → SYNC 0x0 and record 0x0_0080_5A_0_1 (index 0, write).
- TPM read 0xD40C with window 1 at 0xD408 and `rd_ack_i` after 3 clocks, data 0xC3 → three SYNC 0x6 then 0x0, LAD 0x3 then 0xC, FTAR 0xF, and record 0x5_D40C_C3_1_0.
- Read of 0x1234 with no window hit → `lad_oe_o` stays 0 for the whole cycle and no record.
- `rd_ack_i` withheld → 16 × 0x6 then 0xA, `rd_req_o` drops, and no record.
- FIFO full with `tready_i`=0 and a write issued → 16 × 0x6, then 0xA, then `drop_cnt_o`=1. A second run with `tready_i` released mid-wait → SYNC 0x0 the clock after space frees.
- `lframe_i` low during RDATA → `lad_oe_o` is 0 that clock, the new START is accepted, and no record.
